vcmd_v1: RTL and testbench

//  Video command decoder between the SPI byte receiver and the frame-buffer write port.

---
 rtl/vcmd_v1.sv | 114 +++++++++++
 tb/tb_vcmd_v1.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcmd_v1.sv
// Video command decoder: turns a synchronised SPI byte stream into frame-buffer write strobes
// with a persistent auto-incrementing address (NOP / WRITE / SETADDR / CLRADDR headers).
module vcmd_v1 #(
  parameter int unsigned AWIDTH = 18,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              Clk,
  input  logic              NReset,
  input  logic              ByteClkIn,
  input  logic [DWIDTH-1:0] ByteIn,
  input  logic              DataModeEnable,
  output logic              DataClkOut,
  output logic [DWIDTH-1:0] DataOut,
  output logic [AWIDTH-1:0] AddrOut,
  output logic              Busy
);

  typedef enum logic [2:0] {
    StIdle,
    StWData,
    StAddr0,
    StAddr1,
    StAddr2
  } state_e;

  state_e                state_q;
  // [0],[1] are the synchroniser stages, [2] holds the previous level for edge detection
  logic [2:0]            sync_q;
  logic [7:0]            remain_q;
  logic [2*DWIDTH-1:0]   addr_hi_q;
  logic                  incr_q;

  logic                  byte_stb;
  logic [6:0]            pix_cnt;
  logic [7:0]            wr_len;
  logic [3*DWIDTH-1:0]   addr_full;

  assign byte_stb  = sync_q[1] & ~sync_q[2];
  // A zero length field means 64 pixels; the extra top bit encodes exactly that.
  assign pix_cnt   = {ByteIn[5:0] == 6'd0, ByteIn[5:0]};
  assign wr_len    = {1'b0, pix_cnt} + {pix_cnt, 1'b0};
  assign addr_full = {addr_hi_q, ByteIn};

  always_ff @(posedge Clk) begin
    if (!NReset) begin
      sync_q     <= '0;
      state_q    <= StIdle;
      remain_q   <= '0;
      addr_hi_q  <= '0;
      incr_q     <= 1'b0;
      DataClkOut <= 1'b0;
      DataOut    <= '0;
      AddrOut    <= '0;
      Busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], ByteClkIn};
      DataClkOut <= 1'b0;
      incr_q     <= 1'b0;
      // Address advances the cycle after a strobe so it is stable during the pulse.
      if (incr_q) AddrOut <= AddrOut + AWIDTH'(1);

      if (!DataModeEnable) begin
        state_q <= StIdle;
        Busy    <= 1'b0;
      end else if (byte_stb) begin
        unique case (state_q)
          StIdle: begin
            case (ByteIn[7:6])
              2'b01: begin
                remain_q <= wr_len;
                state_q  <= StWData;
                Busy     <= 1'b1;
              end
              2'b10: begin
                state_q <= StAddr0;
                Busy    <= 1'b1;
              end
              2'b11:   AddrOut <= '0;
              default: ;
            endcase
          end
          StWData: begin
            DataOut    <= ByteIn;
            DataClkOut <= 1'b1;
            incr_q     <= 1'b1;
            remain_q   <= remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              state_q <= StIdle;
              Busy    <= 1'b0;
            end
          end
          StAddr0: begin
            addr_hi_q <= {addr_hi_q[DWIDTH-1:0], ByteIn};
            state_q   <= StAddr1;
          end
          StAddr1: begin
            addr_hi_q <= {addr_hi_q[DWIDTH-1:0], ByteIn};
            state_q   <= StAddr2;
          end
          StAddr2: begin
            AddrOut <= addr_full[AWIDTH-1:0];
            state_q <= StIdle;
            Busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            Busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vcmd_v1.sv
// Self-checking bench for vcmd_v1: directed scenarios plus random command streams, each byte
// compared against a command-level reference model of the decoder.
module tb_vcmd_v1;

  logic        Clk = 1'b0;
  logic        NReset = 1'b0;
  logic        ByteClkIn = 1'b0;
  logic [7:0]  ByteIn = 8'h00;
  logic        DataModeEnable = 1'b0;
  logic        DataClkOut;
  logic [7:0]  DataOut;
  logic [17:0] AddrOut;
  logic        Busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: command-level interpretation of the byte stream.
  int         m_addr = 0;
  int         m_pay  = 0;
  int         m_acnt = 0;
  int         m_acc  = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_en   = 1'b0;

  vcmd_v1 #(.AWIDTH(18), .DWIDTH(8)) dut (
    .Clk           (Clk),
    .NReset        (NReset),
    .ByteClkIn     (ByteClkIn),
    .ByteIn        (ByteIn),
    .DataModeEnable(DataModeEnable),
    .DataClkOut    (DataClkOut),
    .DataOut       (DataOut),
    .AddrOut       (AddrOut),
    .Busy          (Busy)
  );

  always #5 Clk = ~Clk;

  // Expected tuple: {strobe, data, addr at strobe time, stray strobe, addr after, busy after}
  task automatic model_byte(input logic [7:0] b, output logic [46:0] exp);
    logic stb;
    int   a_at;
    stb = 1'b0;
    if (!m_en) begin
      a_at = m_addr;
    end else if (m_pay > 0) begin
      stb    = 1'b1;
      a_at   = m_addr;
      m_data = b;
      m_addr = (m_addr + 1) % (1 << 18);
      m_pay--;
    end else if (m_acnt > 0) begin
      m_acc = (m_acc << 8) | int'(b);
      m_acnt--;
      if (m_acnt == 0) m_addr = m_acc % (1 << 18);
      a_at = m_addr;
    end else begin
      case (b[7:6])
        2'd1: m_pay = 3 * ((b[5:0] == 6'd0) ? 64 : int'(b[5:0]));
        2'd2: begin m_acnt = 3; m_acc = 0; end
        2'd3: m_addr = 0;
        default: ;
      endcase
      a_at = m_addr;
    end
    exp = {stb, m_data, a_at[17:0], 1'b0, m_addr[17:0], (m_pay > 0 || m_acnt > 0)};
  endtask

  // Drives one byte strobe and samples the outputs over the following six cycles.
  task automatic send_byte(input logic [7:0] b, output logic [46:0] got);
    logic        stb, extra;
    logic [7:0]  d;
    logic [17:0] a;
    stb = 1'b0; extra = 1'b0; d = '0; a = '0;
    @(negedge Clk);
    ByteIn    = b;
    ByteClkIn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge Clk);
      #1;
      if (i == 3) begin
        stb = DataClkOut; d = DataOut; a = AddrOut;
        ByteClkIn = 1'b0;
      end else if (DataClkOut) begin
        extra = 1'b1;
      end
    end
    got = {stb, d, a, extra, AddrOut, Busy};
  endtask

  task automatic set_enable(input logic v);
    @(negedge Clk);
    DataModeEnable = v;
    m_en = v;
    if (!v) begin m_pay = 0; m_acnt = 0; end
    repeat (2) @(posedge Clk);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    #1;
    n_cmp++;
    if ({DataClkOut, DataOut, AddrOut, Busy} !== 28'h0) begin
      n_bad++;
      $display("FAIL reset: got clk=%b data=%h addr=%h busy=%b, want all zero",
               DataClkOut, DataOut, AddrOut, Busy);
    end
    @(negedge Clk);
    NReset = 1'b1;
  endtask

  task automatic test_write;
    logic [7:0]  s [8] = '{8'h41, 8'hC0, 8'hC0, 8'hC0, 8'h41, 8'h03, 8'h03, 8'h03};
    logic [46:0] exp, got;
    set_enable(1'b1);
    for (int i = 0; i < 8; i++) begin
      model_byte(s[i], exp);
      send_byte(s[i], got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL write byte %0d (%h): got %h want %h", i, s[i], got, exp);
      end
    end
    n_cmp++;
    if (AddrOut !== 18'd6) begin
      n_bad++;
      $display("FAIL write end addr: got %h want 00006", AddrOut);
    end
  endtask

  task automatic test_wrap;
    logic [7:0]  s [8] = '{8'h80, 8'h03, 8'hFF, 8'hFF, 8'h41, 8'h11, 8'h22, 8'h33};
    logic [46:0] exp, got;
    for (int i = 0; i < 8; i++) begin
      model_byte(s[i], exp);
      send_byte(s[i], got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL wrap byte %0d (%h): got %h want %h", i, s[i], got, exp);
      end
    end
    n_cmp++;
    if (AddrOut !== 18'd2) begin
      n_bad++;
      $display("FAIL wrap end addr: got %h want 00002", AddrOut);
    end
  endtask

  task automatic test_disable;
    logic [7:0]  s [5] = '{8'h41, 8'hAA, 8'hAA, 8'hAA, 8'hC0};
    logic [46:0] exp, got;
    set_enable(1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) set_enable(1'b1);
      model_byte(s[i], exp);
      send_byte(s[i], got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL disable byte %0d (%h): got %h want %h", i, s[i], got, exp);
      end
    end
    n_cmp++;
    if (AddrOut !== 18'd0) begin
      n_bad++;
      $display("FAIL clraddr: got %h want 00000", AddrOut);
    end
  endtask

  task automatic test_reset_midburst;
    logic [7:0]  s [4] = '{8'h41, 8'h55, 8'h55, 8'h55};
    logic [46:0] exp, got;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        @(negedge Clk);
        NReset = 1'b0;
        @(posedge Clk);
        #1;
        n_cmp++;
        if ({DataClkOut, DataOut, AddrOut, Busy} !== 28'h0) begin
          n_bad++;
          $display("FAIL midburst reset: got clk=%b data=%h addr=%h busy=%b, want all zero",
                   DataClkOut, DataOut, AddrOut, Busy);
        end
        @(negedge Clk);
        NReset = 1'b1;
        m_addr = 0; m_pay = 0; m_acnt = 0; m_data = 8'h00;
      end
      model_byte(s[i], exp);
      send_byte(s[i], got);
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL midburst byte %0d (%h): got %h want %h", i, s[i], got, exp);
      end
    end
  endtask

  task automatic test_len64;
    logic [46:0] exp, got;
    logic [7:0]  b;
    int          strobes = 0;
    int          start;
    set_enable(1'b0);
    set_enable(1'b1);
    start = m_addr;
    for (int i = 0; i < 193; i++) begin
      b = (i == 0) ? 8'h40 : 8'($urandom_range(0, 255));
      model_byte(b, exp);
      send_byte(b, got);
      if (got[46]) strobes++;
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL len64 byte %0d (%h): got %h want %h", i, b, got, exp);
      end
    end
    n_cmp++;
    if (strobes != 192 || AddrOut !== 18'((start + 192) % (1 << 18)) || Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len64 totals: got strobes=%0d addr=%h busy=%b, want 192 %h 0",
               strobes, AddrOut, Busy, 18'((start + 192) % (1 << 18)));
    end
  endtask

  task automatic test_random;
    logic [7:0]  q[$];
    logic [46:0] exp, got;
    int          k, len;
    for (int c = 0; c < 40; c++) begin
      q.delete();
      k = $urandom_range(0, 9);
      if (k == 0) set_enable(!m_en);
      case (k)
        1, 2, 3, 4: begin
          len = $urandom_range(1, 3);
          q.push_back(8'h40 | 8'(len));
          for (int j = 0; j < 3 * len; j++) q.push_back(8'($urandom_range(0, 255)));
        end
        5, 6: begin
          q.push_back(8'h80 | 8'($urandom_range(0, 63)));
          q.push_back(($urandom_range(0, 1) == 1) ? 8'h03 : 8'($urandom_range(0, 255)));
          q.push_back(8'($urandom_range(0, 255)));
          q.push_back(8'($urandom_range(0, 255)));
        end
        7:       q.push_back(8'hC0 | 8'($urandom_range(0, 63)));
        8:       q.push_back(8'($urandom_range(0, 63)));
        default: q.push_back(8'($urandom_range(0, 255)));
      endcase
      foreach (q[j]) begin
        model_byte(q[j], exp);
        send_byte(q[j], got);
        n_cmp++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL random cmd %0d byte %0d (%h): got %h want %h", c, j, q[j], got, exp);
        end
      end
    end
    set_enable(1'b1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrap();
    test_disable();
    test_reset_midburst();
    test_len64();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
